// File: rtl/lcd_bus_sequencer.sv
// HD44780-style write-only LCD bus sequencer: power-up hold-off, then per-word
// setup / E pulse / hold / execution-wait timing from one shared down-counter.
module lcd_bus_sequencer #(
    parameter int unsigned PWRUP_CYCLES     = 1500000,
    parameter int unsigned SETUP_CYCLES     = 4,
    parameter int unsigned E_HIGH_CYCLES    = 45,
    parameter int unsigned HOLD_CYCLES      = 2,
    parameter int unsigned CMD_WAIT_CYCLES  = 3700,
    parameter int unsigned LONG_WAIT_CYCLES = 152000
) (
    input  logic       clock_i,
    input  logic       rstn_i,
    input  logic [8:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o
);

    localparam int unsigned MAX_A   = (PWRUP_CYCLES > SETUP_CYCLES) ? PWRUP_CYCLES : SETUP_CYCLES;
    localparam int unsigned MAX_B   = (E_HIGH_CYCLES > HOLD_CYCLES) ? E_HIGH_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_C   = (CMD_WAIT_CYCLES > LONG_WAIT_CYCLES) ? CMD_WAIT_CYCLES : LONG_WAIT_CYCLES;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t PWRUP_LD = cnt_t'(PWRUP_CYCLES - 1);
    localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYCLES - 1);
    localparam cnt_t EHIGH_LD = cnt_t'(E_HIGH_CYCLES - 1);
    localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t CMDW_LD  = cnt_t'(CMD_WAIT_CYCLES - 1);
    localparam cnt_t LONGW_LD = cnt_t'(LONG_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_WAIT
    } state_e;

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       e_q, e_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       long_q, long_d;
    logic       cnt_zero;
    logic       long_sel;

    assign cnt_zero = (cnt_q == '0);

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign long_sel = !data_i[8] && (data_i[7:2] == '0) && (data_i[1:0] != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        long_d  = long_q;
        unique case (state_q)
            ST_PWRUP: begin
                if (cnt_zero) state_d = ST_IDLE;
                else          cnt_d   = cnt_q - 1'b1;
            end
            ST_IDLE: begin
                if (valid_i) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    rs_d    = data_i[8];
                    data_d  = data_i[7:0];
                    long_d  = long_sel;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_EHIGH;
                    cnt_d   = EHIGH_LD;
                    e_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EHIGH: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    e_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_WAIT;
                    cnt_d   = long_q ? LONGW_LD : CMDW_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) state_d = ST_IDLE;
                else          cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = PWRUP_LD;
                e_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_PWRUP;
            cnt_q   <= PWRUP_LD;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
        end
    end

    assign ready_o    = (state_q == ST_IDLE);
    assign busy_o     = (state_q != ST_IDLE);
    assign lcd_e_o    = e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign lcd_rw_o   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: a timeline model of when each output must change,
// an in-order word scoreboard on E pulses, and directed transfer scenarios.
module tb_lcd_bus_sequencer;

    localparam int P  = 20;
    localparam int S  = 2;
    localparam int E  = 4;
    localparam int H  = 2;
    localparam int CW = 10;
    localparam int LW = 50;

    logic       clk;
    logic       rstn;
    logic [8:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       busy_o;
    logic       lcd_rs_o;
    logic       lcd_rw_o;
    logic       lcd_e_o;
    logic [7:0] lcd_data_o;

    int vectors = 0;
    int errs    = 0;

    lcd_bus_sequencer #(
        .PWRUP_CYCLES    (P),
        .SETUP_CYCLES    (S),
        .E_HIGH_CYCLES   (E),
        .HOLD_CYCLES     (H),
        .CMD_WAIT_CYCLES (CW),
        .LONG_WAIT_CYCLES(LW)
    ) dut (
        .clock_i   (clk),
        .rstn_i    (rstn),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .lcd_rs_o  (lcd_rs_o),
        .lcd_rw_o  (lcd_rw_o),
        .lcd_e_o   (lcd_e_o),
        .lcd_data_o(lcd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: edges counted since reset release; an accepted word at
    // edge t0 raises E over [t0+S, t0+S+E) and frees the bus at t0+S+E+H+wait.
    int         m_cyc;
    int         m_t0;
    int         m_wl;
    logic       m_busy_xfer;
    logic [8:0] m_word;
    logic       m_ready;
    logic       m_e;

    initial begin
        m_cyc = 0; m_t0 = 0; m_wl = CW; m_busy_xfer = 1'b0;
        m_word = '0; m_ready = 1'b0; m_e = 1'b0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_cyc = 0; m_busy_xfer = 1'b0; m_word = '0;
                m_ready = 1'b0; m_e = 1'b0;
            end else begin
                m_cyc++;
                if (m_ready && valid_i) begin
                    m_t0        = m_cyc;
                    m_word      = data_i;
                    m_busy_xfer = 1'b1;
                    m_wl = (data_i == 9'h001 || data_i == 9'h002 || data_i == 9'h003) ? LW : CW;
                end
                if (m_busy_xfer) begin
                    m_e     = (m_cyc >= m_t0 + S) && (m_cyc < m_t0 + S + E);
                    m_ready = (m_cyc >= m_t0 + S + E + H + m_wl);
                    if (m_ready) m_busy_xfer = 1'b0;
                end else begin
                    m_e     = 1'b0;
                    m_ready = (m_cyc >= P);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("ready", 32'(ready_o), 32'(m_ready));
            check("busy", 32'(busy_o), 32'(!m_ready));
            check("lcd_e", 32'(lcd_e_o), 32'(m_e));
            check("lcd_rs", 32'(lcd_rs_o), 32'(m_word[8]));
            check("lcd_data", 32'(lcd_data_o), 32'(m_word[7:0]));
            check("lcd_rw", 32'(lcd_rw_o), 32'(1'b0));
        end
    end

    // Word scoreboard: each handshake must show up once, in order, at an E rise.
    logic [8:0] sb_q[$];
    int         hs_cnt = 0;
    int         e_cnt  = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) sb_q.delete();
            else if (ready_o && valid_i) begin
                sb_q.push_back(data_i);
                hs_cnt++;
            end
        end
    end

    initial begin
        logic prev_e;
        logic [8:0] exp_w;
        prev_e = 1'b0;
        forever begin
            @(negedge clk);
            if (lcd_e_o && !prev_e) begin
                e_cnt++;
                check("sb_pending", 32'(sb_q.size() > 0), 32'(1));
                if (sb_q.size() > 0) begin
                    exp_w = sb_q.pop_front();
                    check("sb_word", 32'({lcd_rs_o, lcd_data_o}), 32'(exp_w));
                end
            end
            prev_e = lcd_e_o;
        end
    end

    // Counts edges from reset release until ready; called at the release negedge.
    task automatic pwrup_measure(input string tag);
        int n;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n), 32'(20));
    endtask

    // One isolated transfer; n counts edges from the handshake cycle.
    task automatic xfer(input logic [8:0] w, input int exp_total, input string tag);
        int n, efirst, ehigh, guard;
        data_i  = w;
        valid_i = 1'b1;
        guard   = 0;
        while (!ready_o && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready_seen"}, 32'(ready_o), 32'(1));
        n = 0; efirst = -1; ehigh = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                valid_i = 1'b0;
                check({tag, "_ready_drop"}, 32'(ready_o), 32'(0));
                check({tag, "_pins"}, 32'({lcd_rs_o, lcd_data_o}), 32'(w));
            end
            if (lcd_e_o) begin
                if (efirst < 0) efirst = n;
                ehigh++;
            end
        end while (!ready_o && n < 1000);
        check({tag, "_cycle"}, 32'(n), 32'(exp_total));
        check({tag, "_e_rise"}, 32'(efirst), 32'(3));
        check({tag, "_e_width"}, 32'(ehigh), 32'(4));
    endtask

    // Streaming send: holds valid until taken, scrambling data while blocked.
    task automatic send(input logic [8:0] w, input int gap);
        int guard;
        valid_i = 1'b1;
        guard   = 0;
        while (!ready_o && guard < 1000) begin
            data_i = guard[0] ? ~w : w;
            @(negedge clk);
            guard++;
        end
        data_i = w;
        check("stream_ready_seen", 32'(ready_o), 32'(1));
        @(negedge clk);
        if (gap > 0) begin
            valid_i = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    logic [8:0] stream_w [10] = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h148,
                                   9'h165, 9'h16C, 9'h080, 9'h102, 9'h003};
    int         stream_g [10] = '{0, 3, 0, 1, 0, 0, 7, 2, 0, 0};

    initial begin
        int guard;
        rstn    = 1'b0;
        valid_i = 1'b1;
        data_i  = 9'h038;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(1));
        check("rst_data", 32'(lcd_data_o), 32'(0));
        rstn = 1'b1;

        pwrup_measure("pwrup_edges");
        xfer(9'h038, 19, "cmd38");
        xfer(9'h141, 19, "charA");
        xfer(9'h001, 59, "clear");
        xfer(9'h101, 19, "rs1_01");
        xfer(9'h002, 59, "home2");
        xfer(9'h003, 59, "home3");
        xfer(9'h004, 19, "entry04");
        xfer(9'h000, 19, "nop00");

        for (int i = 0; i < 10; i++) send(stream_w[i], stream_g[i]);
        valid_i = 1'b0;
        guard = 0;
        while (!ready_o && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("stream_drain", 32'(ready_o), 32'(1));

        data_i  = 9'h1AA;
        valid_i = 1'b1;
        guard   = 0;
        while (!lcd_e_o && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("midpulse_e_seen", 32'(lcd_e_o), 32'(1));
        #1 rstn = 1'b0;
        #1;
        check("arst_e", 32'(lcd_e_o), 32'(0));
        check("arst_ready", 32'(ready_o), 32'(0));
        check("arst_busy", 32'(busy_o), 32'(1));
        check("arst_rs", 32'(lcd_rs_o), 32'(0));
        check("arst_data", 32'(lcd_data_o), 32'(0));
        check("arst_rw", 32'(lcd_rw_o), 32'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        pwrup_measure("repwrup_edges");
        xfer(9'h038, 19, "post_rst");

        repeat (3) @(negedge clk);
        check("e_pulses_vs_handshakes", 32'(e_cnt), 32'(hs_cnt));
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
